// File: rtl/hex_step_counter_if.sv
// Button/load inputs and decoder-facing outputs of hex_step_counter.
interface hex_step_counter_if;
  logic       key_up_n;
  logic       key_dn_n;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] value;
  logic       blank;
  logic       step;

  modport master (
    output key_up_n, key_dn_n, load, load_val,
    input  value, blank, step
  );

  modport slave (
    input  key_up_n, key_dn_n, load, load_val,
    output value, blank, step
  );
endinterface

// File: rtl/hex_step_counter.sv
// Debounced up/down hex counter feeding the HEX0 seven-segment decoder.
// Define HEX_STEP_AUTO_REPEAT_EN to enable hold-to-repeat stepping.
module hex_step_counter #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int MAX_VAL         = 15
) (
  input logic               CLOCK_50,
  input logic               reset_n,
  hex_step_counter_if.slave bus
);

  localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
  localparam logic [3:0]      MAX_V   = 4'(MAX_VAL);

`ifdef HEX_STEP_AUTO_REPEAT_EN
  localparam int RD_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RR_CYC = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int TM_MAX = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
  localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;
  localparam logic [TM_W-1:0] RD_LAST = TM_W'(RD_CYC - 1);
  localparam logic [TM_W-1:0] RR_LAST = TM_W'(RR_CYC - 1);

  logic [TM_W-1:0] timer;
`endif

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t          state;
  logic [1:0]      up_sync;
  logic [1:0]      dn_sync;
  logic [1:0]      sync_vld;
  logic [1:0]      sync_lvl;
  logic [1:0]      db_lvl;
  logic [1:0]      lock;
  logic [DB_W-1:0] db_cnt [2];
  logic            up_act;
  logic            dn_act;
  logic            up_act_q;
  logic            dn_act_q;
  logic            up_rise;
  logic            dn_rise;
  logic            dir_up;
  logic            keep_hold;
  logic            do_step;
  logic            step_up;
  logic [3:0]      step_val;
  logic [3:0]      load_clamped;
  logic [3:0]      value_q;
  logic            blank_q;
  logic            step_q;

  // Key levels are kept active-high (1 = pressed); bit 0 is up, bit 1 is down.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      up_sync  <= 2'b00;
      dn_sync  <= 2'b00;
      sync_vld <= 2'b00;
    end else begin
      up_sync  <= {up_sync[0], ~bus.key_up_n};
      dn_sync  <= {dn_sync[0], ~bus.key_dn_n};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign sync_lvl = {dn_sync[1], up_sync[1]};

  // A key still held when reset lifts stays locked until it is seen released.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      db_lvl <= 2'b00;
      lock   <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!sync_vld[1]) begin
          db_cnt[i] <= '0;
        end else begin
          if (!sync_lvl[i] && !db_lvl[i]) begin
            lock[i] <= 1'b0;
          end
          if (sync_lvl[i] != db_lvl[i]) begin
            if (db_cnt[i] == DB_LAST) begin
              db_lvl[i] <= sync_lvl[i];
              db_cnt[i] <= '0;
            end else begin
              db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
          end else begin
            db_cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign up_act  = db_lvl[0] & ~db_lvl[1] & ~lock[0];
  assign dn_act  = db_lvl[1] & ~db_lvl[0] & ~lock[1];
  assign up_rise = up_act & ~up_act_q;
  assign dn_rise = dn_act & ~dn_act_q;

  always_comb begin
    keep_hold = dir_up ? up_act : dn_act;
    do_step   = 1'b0;
    step_up   = dir_up;
    case (state)
      IDLE: begin
        if (up_rise || dn_rise) begin
          do_step = 1'b1;
          step_up = up_rise;
        end
      end
`ifdef HEX_STEP_AUTO_REPEAT_EN
      HOLD:    do_step = keep_hold && (timer == RD_LAST);
      REPEAT:  do_step = keep_hold && (timer == RR_LAST);
`endif
      default: do_step = 1'b0;
    endcase
  end

  always_comb begin
    if (step_up) begin
      step_val = (value_q == MAX_V) ? 4'd0 : value_q + 4'd1;
    end else begin
      step_val = (value_q == 4'd0) ? MAX_V : value_q - 4'd1;
    end
    load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
  end

  // Load overrides a same-cycle step on the outputs but never touches the FSM.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state    <= IDLE;
      dir_up   <= 1'b0;
      up_act_q <= 1'b0;
      dn_act_q <= 1'b0;
      value_q  <= 4'd0;
      blank_q  <= 1'b1;
      step_q   <= 1'b0;
`ifdef HEX_STEP_AUTO_REPEAT_EN
      timer    <= '0;
`endif
    end else begin
      up_act_q <= up_act;
      dn_act_q <= dn_act;
      case (state)
        IDLE: begin
          if (up_rise || dn_rise) begin
            state  <= HOLD;
            dir_up <= up_rise;
`ifdef HEX_STEP_AUTO_REPEAT_EN
            timer  <= '0;
`endif
          end
        end
        HOLD: begin
          if (!keep_hold) begin
            state <= IDLE;
          end
`ifdef HEX_STEP_AUTO_REPEAT_EN
          else if (timer == RD_LAST) begin
            state <= REPEAT;
            timer <= '0;
          end else begin
            timer <= timer + TM_W'(1);
          end
`endif
        end
`ifdef HEX_STEP_AUTO_REPEAT_EN
        REPEAT: begin
          if (!keep_hold) begin
            state <= IDLE;
          end else if (timer == RR_LAST) begin
            timer <= '0;
          end else begin
            timer <= timer + TM_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase

      if (bus.load) begin
        value_q <= load_clamped;
        blank_q <= 1'b0;
        step_q  <= 1'b0;
      end else if (do_step) begin
        value_q <= step_val;
        blank_q <= 1'b0;
        step_q  <= 1'b1;
      end else begin
        step_q  <= 1'b0;
      end
    end
  end

  assign bus.value = value_q;
  assign bus.blank = blank_q;
  assign bus.step  = step_q;

endmodule

// File: tb/tb_hex_step_counter.sv
// Bench for hex_step_counter: one DUT at MAX_VAL=15 and one at MAX_VAL=10 share stimulus.
module tb_hex_step_counter;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;

  hex_step_counter_if bus ();
  hex_step_counter_if bus10 ();

  assign bus10.key_up_n = bus.key_up_n;
  assign bus10.key_dn_n = bus.key_dn_n;
  assign bus10.load     = bus.load;
  assign bus10.load_val = bus.load_val;

  hex_step_counter #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(5), .MAX_VAL(15)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  hex_step_counter #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(5), .MAX_VAL(10)
  ) dut10 (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus10)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst_n;
    logic       up_n;
    logic       dn_n;
    logic       ld;
    logic [3:0] ldv;
    logic [3:0] e15;
    logic [3:0] e10;
    logic       eb;
    logic       es;
  } vec_t;

  vec_t tab[$];

  // Reference model: keys tracked as levels, stepping derived from how long a key has been held.
  bit         m_s1[2], m_s2[2], m_db[2], m_lock[2], m_prev[2];
  int         m_run[2];
  int         m_since;
  bit         m_holding, m_hold_up;
  int         m_hold_n;
  logic [3:0] m_v15, m_v10;
  bit         m_blank, m_step;

  function automatic int wrap_step(int v, int mx, bit up);
    return up ? (v + 1) % (mx + 1) : (v + mx) % (mx + 1);
  endfunction

  task automatic model_edge(input bit rst_n, up_n, dn_n, ld, input logic [3:0] ldv);
    bit act[2];
    bit raw[2];
    bit fire, fire_up, keep;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_db[k] = 0; m_lock[k] = 1; m_prev[k] = 0; m_run[k] = 0;
      end
      m_since = 0; m_holding = 0; m_hold_up = 0; m_hold_n = 0;
      m_v15 = 0; m_v10 = 0; m_blank = 1; m_step = 0;
      return;
    end
    raw[0] = !up_n;
    raw[1] = !dn_n;
    act[0] = m_db[0] && !m_db[1] && !m_lock[0];
    act[1] = m_db[1] && !m_db[0] && !m_lock[1];
    fire = 0;
    fire_up = 0;
    if (m_holding) begin
      keep = m_hold_up ? act[0] : act[1];
      if (!keep) begin
        m_holding = 0;
      end else begin
        m_hold_n++;
`ifdef HEX_STEP_AUTO_REPEAT_EN
        if (m_hold_n == RD || (m_hold_n > RD && (m_hold_n - RD) % RR == 0)) begin
          fire = 1;
          fire_up = m_hold_up;
        end
`endif
      end
    end else if ((act[0] && !m_prev[0]) || (act[1] && !m_prev[1])) begin
      fire = 1;
      fire_up = act[0];
      m_holding = 1;
      m_hold_up = act[0];
      m_hold_n = 0;
    end
    m_prev[0] = act[0];
    m_prev[1] = act[1];
    if (ld) begin
      m_v15 = (ldv > 15) ? 4'd15 : ldv;
      m_v10 = (ldv > 10) ? 4'd10 : ldv;
      m_blank = 0;
      m_step = 0;
    end else if (fire) begin
      m_v15 = 4'(wrap_step(int'(m_v15), 15, fire_up));
      m_v10 = 4'(wrap_step(int'(m_v10), 10, fire_up));
      m_blank = 0;
      m_step = 1;
    end else begin
      m_step = 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_since >= 2) begin
        if (!m_s2[k] && !m_db[k]) m_lock[k] = 0;
        if (m_s2[k] != m_db[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_db[k] = m_s2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
    m_since++;
  endtask

  task automatic apply_stimulus(input logic rst_n, up_n, dn_n, ld, input logic [3:0] ldv);
    reset_n = rst_n;
    bus.key_up_n = up_n;
    bus.key_dn_n = dn_n;
    bus.load = ld;
    bus.load_val = ldv;
    @(posedge CLOCK_50);
    model_edge(rst_n, up_n, dn_n, ld, ldv);
    #1;
  endtask

  task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] e15, e10, input logic eb, es);
    cmp({tag, "/value"}, bus.value, e15);
    cmp({tag, "/value10"}, bus10.value, e10);
    cmp({tag, "/blank"}, {3'b0, bus.blank}, {3'b0, eb});
    cmp({tag, "/blank10"}, {3'b0, bus10.blank}, {3'b0, eb});
    cmp({tag, "/step"}, {3'b0, bus.step}, {3'b0, es});
    cmp({tag, "/step10"}, {3'b0, bus10.step}, {3'b0, es});
  endtask

  // Holds a key pattern; fire_at = 0 means no step is expected in the window.
  task automatic hold_keys(input string tag, input logic up_n, dn_n, input int ncyc, fire_at,
                           input logic [3:0] b15, b10, a15, a10, input logic blank0);
    bit after;
    for (int c = 1; c <= ncyc; c++) begin
      apply_stimulus(1'b1, up_n, dn_n, 1'b0, 4'd0);
      after = (fire_at != 0) && (c >= fire_at);
      check_output($sformatf("%s@%0d", tag, c), after ? a15 : b15, after ? a10 : b10,
                   after ? 1'b0 : blank0, c == fire_at);
    end
  endtask

  function automatic void add_vec(logic rst_n, up_n, dn_n, ld, logic [3:0] ldv, e15, e10,
                                  logic eb, es);
    vec_t v;
    v.rst_n = rst_n; v.up_n = up_n; v.dn_n = dn_n; v.ld = ld; v.ldv = ldv;
    v.e15 = e15; v.e10 = e10; v.eb = eb; v.es = es;
    tab.push_back(v);
  endfunction

  initial begin
    logic       up_n, dn_n, ld, rn;
    logic [3:0] ldv;
    int         k;
    int         fires[4];
    logic [3:0] seq15[5];
    logic [3:0] seq10[5];

    bus.key_up_n = 1'b1;
    bus.key_dn_n = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;

    for (int i = 0; i < 3; i++) add_vec(0, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) add_vec(1, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) add_vec(1, 0, 1, 0, 0, 4'(i >= 7), 4'(i >= 7), i < 7, i == 7);
    for (int i = 0; i < 6; i++) add_vec(1, 1, 1, 0, 0, 1, 1, 0, 0);
    add_vec(1, 1, 1, 1, 12, 12, 10, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(1, 1, 1, 0, 0, 12, 10, 0, 0);

    foreach (tab[i]) begin
      apply_stimulus(tab[i].rst_n, tab[i].up_n, tab[i].dn_n, tab[i].ld, tab[i].ldv);
      check_output($sformatf("vec%0d", i), tab[i].e15, tab[i].e10, tab[i].eb, tab[i].es);
    end

    for (int c = 0; c < 12; c++) begin
      apply_stimulus(1'b1, 1'b1, ((c / 2) % 2) != 0, 1'b0, 4'd0);
      check_output($sformatf("bounce@%0d", c), 12, 10, 1'b0, 1'b0);
    end
    hold_keys("bounce_rel", 1, 1, 8, 0, 12, 10, 12, 10, 0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    check_output("load0", 0, 0, 1'b0, 1'b0);
    hold_keys("clean_dn", 1, 0, 10, 7, 0, 0, 15, 10, 0);
    hold_keys("clean_dn_rel", 1, 1, 8, 0, 15, 10, 15, 10, 0);

    hold_keys("both", 0, 0, 15, 0, 15, 10, 15, 10, 0);
    hold_keys("both_rel", 1, 1, 8, 0, 15, 10, 15, 10, 0);

    for (int c = 1; c <= 10; c++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, c == 7, 4'd9);
      check_output($sformatf("load_prio@%0d", c), (c < 7) ? 4'd15 : 4'd9, (c < 7) ? 4'd10 : 4'd9,
                   1'b0, 1'b0);
    end
    hold_keys("load_prio_rel", 1, 1, 8, 0, 9, 9, 9, 9, 0);

    hold_keys("pre_rst", 0, 1, 10, 7, 9, 9, 10, 10, 0);
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      check_output($sformatf("rst_held@%0d", c), 0, 0, 1'b1, 1'b0);
    end
    hold_keys("held_after_rst", 0, 1, 15, 0, 0, 0, 0, 0, 1);
    hold_keys("held_rel", 1, 1, 10, 0, 0, 0, 0, 0, 1);
    hold_keys("repress", 0, 1, 10, 7, 0, 0, 1, 1, 1);
    hold_keys("repress_rel", 1, 1, 8, 0, 1, 1, 1, 1, 0);

`ifdef HEX_STEP_AUTO_REPEAT_EN
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd14);
    check_output("load14", 14, 10, 1'b0, 1'b0);
    fires = '{7, 27, 32, 37};
    seq15 = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    seq10 = '{4'd10, 4'd0, 4'd1, 4'd2, 4'd3};
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      bit s;
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      s = 0;
      if (k < 4 && c == fires[k]) begin
        k++;
        s = 1;
      end
      check_output($sformatf("repeat@%0d", c), seq15[k], seq10[k], 1'b0, s);
    end
`else
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    check_output("load0b", 0, 0, 1'b0, 1'b0);
    hold_keys("single", 0, 1, 40, 7, 0, 0, 1, 1, 0);
`endif
    hold_keys("hold_rel", 1, 1, 8, 0, bus.value, bus10.value, bus.value, bus10.value, 0);

    up_n = 1'b1;
    dn_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b0, up_n, dn_n, 1'b0, 4'd0);
      check_output("rand_rst", m_v15, m_v10, m_blank, m_step);
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) up_n = ~up_n;
      if ($urandom_range(0, 23) == 0) dn_n = ~dn_n;
      ld  = ($urandom_range(0, 59) == 0);
      ldv = 4'($urandom_range(0, 15));
      rn  = !($urandom_range(0, 799) == 0);
      apply_stimulus(rn, up_n, dn_n, ld, ldv);
      check_output($sformatf("rand%0d", i), m_v15, m_v10, m_blank, m_step);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_step_counter.md
Name: hex_step_counter

Overview:
- Upstream source for the HEX0 seven-segment decoder stage.
- Converts raw active-low pushbuttons into a debounced 4-bit hex value, stepped up or down with wrap-around.
- Supports a parallel load from the slide switches.
- Drives the decoder's 4-bit nibble input plus a blank request. The decoder owns the segment patterns; this block only produces the value.

Parameters:
- CLK_HZ, 50000000, clock frequency in Hz.
- DEBOUNCE_MS, 10, stable time required before a key level is accepted. DB_CYC = CLK_HZ/1000*DEBOUNCE_MS; DB_CYC must be ≥ 1.
- REPEAT_DELAY_MS, 500, hold time before auto-repeat starts. RD_CYC = CLK_HZ/1000*REPEAT_DELAY_MS.
- REPEAT_RATE_MS, 100, interval between auto-repeat steps. RR_CYC = CLK_HZ/1000*REPEAT_RATE_MS.
- MAX_VAL, 15, highest count value (1..15). The count wraps between 0 and MAX_VAL.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- key_up_n  in  1  raw, asynchronous up button; 0 = pressed.
- key_dn_n  in  1  raw, asynchronous down button; 0 = pressed.
- load  in  1  synchronous load strobe (level).
- load_val  in  4  value to load.
- value  out  4  current count; feeds the decoder's nibble input.
- blank  out  1  1 = decoder should show blank.
- step  out  1  one-cycle pulse on every value change caused by a key.

Behaviour:
- Reset: sampled on the CLOCK_50 rising edge while reset_n=0. Clears value=0, blank=1, step=0, FSM=IDLE, debounced levels=released, and all timers. Reset mid-hold discards the press; after reset releases, a key held throughout reset yields no step until it is released and pressed again.
- Input sync: each raw key passes through a 2-flop synchronizer.
- Debounce: per-key counter. Whenever the synced level differs from the debounced level for DB_CYC consecutive cycles, the debounced level flips. Any bounce back resets the counter.
- Latency: raw key falling edge to value update is DB_CYC+3 cycles for a clean edge. step pulses in the same cycle that value updates.
- Key resolution: up_act = debounced up pressed and down released; dn_act is the mirror. Both pressed counts as neither.
- FSM states and transitions:
  - IDLE: on a rising edge of up_act or dn_act, step once, clear the timer, go to HOLD.
  - HOLD: timer counts. If the active key releases or both keys are pressed, go to IDLE. If timer = RD_CYC-1, step, clear the timer, go to REPEAT.
  - REPEAT: if timer = RR_CYC-1, step and clear the timer. On release or both pressed, go to IDLE.
- Step arithmetic:
  - up: value = (value == MAX_VAL) ? 0 : value+1.
  - down: value = (value == 0) ? MAX_VAL : value-1.
- Load: when load=1, value<=load_val on the next edge (clamped to MAX_VAL if larger), blank<=0, step=0. Load has priority over any key step in the same cycle, and the FSM state is unaffected.
- blank: set by reset, cleared by the first step or load, then stays 0 until the next reset.

Optional Feature:
- Macro: HEX_STEP_AUTO_REPEAT_EN.
- Defined: HOLD and REPEAT behave as above.
- Undefined: no auto-repeat. Exactly one step per debounced press; HOLD only waits for release or both-pressed, then goes to IDLE. The RD_CYC/RR_CYC timer logic is not synthesized.

Test Plan:
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5, MAX_VAL=15, macro defined, unless noted.
- Reset: hold reset_n=0 for 3 cycles with keys released. Expect value=0, blank=1, step=0. Release reset: outputs hold.
- Clean press: key_up_n=0 held for 10 cycles. Expect value 0→1 at cycle 7 (DB_CYC+3) with a single step pulse, blank→0, no further change before the repeat delay.
- Bounce: key_dn_n toggles 0/1 every 2 cycles for 12 cycles, then 1. Expect no step, value unchanged. Then a clean press from value=0 gives value=15.
- Auto-repeat: hold up from value=14 for 40 cycles. Expect steps at debounce+3, then +20, then every 5 cycles: 14→15→0→1→2, each with one step pulse.
- Conflict and load:
  - Both keys pressed: no step.
  - load=1 with load_val=9 in the same cycle an up step would fire: value=9, step=0.
  - load_val=12 with MAX_VAL=10: value=10.
- Macro undefined: hold up for 40 cycles. Expect exactly one step, value 0→1.
